// File: rtl/inst_loader.sv
// inst_loader: packs a length-prefixed byte stream into big-endian words and writes them to instruction memory.
// Optional XOR trailer check is compiled in with INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int WORD = 32,
  parameter int ADDR = 16,
  parameter int BASE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_valid_i,
  input  logic [7:0]      rx_data_i,
  output logic            rx_ready_o,
  input  logic            start_i,
  output logic [ADDR-1:0] mem_a_o,
  output logic            mem_w_o,
  output logic [WORD-1:0] mem_d_o,
  output logic            stall_o,
  output logic            done_o,
  output logic            err_o
);
  typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, WRITE, CHK, DONE} state_t;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CHK;
`else
  localparam state_t TAIL = DONE;
`endif
  state_t state_q, state_d;
  logic [15:0] n_q, n_d, idx_q, idx_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [WORD-1:0] word_q, word_d, mem_d_q, mem_d_d;
  logic [ADDR-1:0] mem_a_q, mem_a_d;
  logic acc;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic err_q, err_d;
  assign err_o   = err_q;
  assign stall_o = !done_o || err_q;
`else
  assign err_o   = 1'b0;
  assign stall_o = !done_o;
`endif
  assign rx_ready_o = state_q inside {CNT_HI, CNT_LO, DATA, CHK};
  assign acc        = rx_valid_i & rx_ready_o;
  assign mem_w_o    = state_q == WRITE;
  assign done_o     = state_q == DONE;
  assign mem_a_o    = mem_a_q;
  assign mem_d_o    = mem_d_q;
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    mem_a_d    = mem_a_q;
    mem_d_d    = mem_d_q;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d     = acc && state_q != CHK ? csum_q ^ rx_data_i : csum_q;
    err_d      = err_q;
`endif
    case (state_q)
      CNT_HI: if (acc) begin
        n_d[15:8] = rx_data_i;
        state_d   = CNT_LO;
      end
      CNT_LO: if (acc) begin
        n_d[7:0] = rx_data_i;
        state_d  = {n_q[15:8], rx_data_i} != 16'd0 ? DATA : TAIL;
      end
      DATA: if (acc) begin
        word_d     = {word_q[WORD-9:0], rx_data_i};
        byte_idx_d = byte_idx_q + 2'd1;
        // address and data are latched here so they hold steady through WRITE and after it
        if (byte_idx_q == 2'd3) begin
          state_d = WRITE;
          mem_a_d = ADDR'(BASE) + ADDR'(idx_q);
          mem_d_d = word_d;
        end
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = idx_d == n_q ? TAIL : DATA;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CHK: if (acc) begin
        err_d   = rx_data_i != csum_q;
        state_d = DONE;
      end
`endif
      DONE: if (start_i) begin
        state_d = CNT_HI;
        idx_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d  = '0;
        err_d   = 1'b0;
`endif
      end
      default: state_d = CNT_HI;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CNT_HI;
      n_q        <= '0;
      idx_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      err_q      <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: table, hand-written and random loads against a stream/word-list reference model.
module tb_inst_loader;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int B0 = 0, A0 = 16, B1 = 3, A1 = 2;
  logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, start_i = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rdy0, w0, stall0, done0, err0, rdy1, w1, stall1, done1, err1;
  logic [15:0] a0;
  logic [1:0] a1;
  logic [31:0] d0, d1;
  int checks = 0, errors = 0;
  logic [31:0] wq[$];
  logic [7:0] bq[$];
  logic [47:0] obs0[$];
  logic [33:0] obs1[$];
  typedef struct {
    int n;
    logic [31:0] w0;
    logic [31:0] w1;
    int mode;
    logic exp_stall;
    logic exp_err;
  } vec_t;
  vec_t tbl[4];

  inst_loader #(.WORD(32), .ADDR(A0), .BASE(B0)) u0 (
    .clk(clk), .reset(reset), .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rdy0),
    .start_i(start_i), .mem_a_o(a0), .mem_w_o(w0), .mem_d_o(d0), .stall_o(stall0),
    .done_o(done0), .err_o(err0));
  inst_loader #(.WORD(32), .ADDR(A1), .BASE(B1)) u1 (
    .clk(clk), .reset(reset), .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rdy1),
    .start_i(start_i), .mem_a_o(a1), .mem_w_o(w1), .mem_d_o(d1), .stall_o(stall1),
    .done_o(done1), .err_o(err1));

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset) begin
    if (w0) begin
      obs0.push_back({a0, d0});
      checks++;
      if (rdy0) begin
        errors++;
        $display("FAIL ready_in_write: rx_ready_o=1 required 0");
      end
    end
    if (w1) obs1.push_back({a1, d1});
  end

  task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk(rdy0, 1, {nm, ".ready"});
    chk(w0, 0, {nm, ".w"});
    chk(a0, 0, {nm, ".a"});
    chk(d0, 0, {nm, ".d"});
    chk(stall0, 1, {nm, ".stall"});
    chk(done0, 0, {nm, ".done"});
    chk(err0, 0, {nm, ".err"});
    chk(a1, 0, {nm, ".a_wrap"});
  endtask

  task automatic build(input logic bad);
    logic [7:0] x;
    int n;
    n = wq.size();
    bq.delete();
    bq.push_back(8'(n >> 8));
    bq.push_back(8'(n));
    foreach (wq[i]) for (int b = 3; b >= 0; b--) bq.push_back(wq[i][8*b +: 8]);
    x = 8'h00;
    foreach (bq[i]) x = x ^ bq[i];
    if (CHK_EN) bq.push_back(x ^ {7'd0, bad});
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rdy0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL byte_timeout: rx_ready_o stayed 0 for %0d cycles, required 1", t);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_all(input int from, input int to, input int mode, input int start_at);
    for (int k = from; k < to; k++) begin
      if (k == start_at) begin
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
      end
      send_byte(bq[k], mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 2)));
    end
  endtask

  task automatic finish_check(input logic es, input logic ee, input string nm);
    int t;
    t = 0;
    while (!done0 && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk(done0, 1, {nm, ".done"});
    chk(stall0, es, {nm, ".stall"});
    chk(err0, ee, {nm, ".err"});
    chk(done1, 1, {nm, ".done_wrap"});
    chk(stall1, es, {nm, ".stall_wrap"});
    chk(obs0.size(), wq.size(), {nm, ".nwrites"});
    chk(obs1.size(), wq.size(), {nm, ".nwrites_wrap"});
    foreach (wq[i]) begin
      if (i < obs0.size()) begin
        chk(obs0[i][47:32], (B0 + i) % (1 << A0), $sformatf("%s.addr%0d", nm, i));
        chk(obs0[i][31:0], wq[i], $sformatf("%s.data%0d", nm, i));
      end
      if (i < obs1.size()) begin
        chk(obs1[i][33:32], (B1 + i) % (1 << A1), $sformatf("%s.addr_wrap%0d", nm, i));
        chk(obs1[i][31:0], wq[i], $sformatf("%s.data_wrap%0d", nm, i));
      end
    end
  endtask

  task automatic rearm(input string nm);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk(done0, 0, {nm, ".rearm_done"});
    chk(stall0, 1, {nm, ".rearm_stall"});
    chk(rdy0, 1, {nm, ".rearm_ready"});
    chk(err0, 0, {nm, ".rearm_err"});
  endtask

  task automatic run_load(input int mode, input int start_at, input logic bad,
                          input logic es, input logic ee, input string nm);
    obs0.delete();
    obs1.delete();
    build(bad);
    send_all(0, bq.size(), mode, start_at);
    finish_check(es, ee, nm);
    rearm(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2, 32'hDEADBEEF, 32'h0000002A, 0, 1'b0, 1'b0};
    tbl[1] = '{2, 32'hDEADBEEF, 32'h0000002A, 1, 1'b0, 1'b0};
    tbl[2] = '{0, 32'h0, 32'h0, 0, 1'b0, 1'b0};
    tbl[3] = '{1, 32'h11223344, 32'h0, 2, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;
    for (int v = 0; v < 4; v++) begin
      wq.delete();
      if (tbl[v].n > 0) wq.push_back(tbl[v].w0);
      if (tbl[v].n > 1) wq.push_back(tbl[v].w1);
      run_load(tbl[v].mode, -1, 1'b0, tbl[v].exp_stall, tbl[v].exp_err, $sformatf("vec%0d", v));
    end
    // start_i pulsed mid-load must be ignored
    wq.delete();
    wq.push_back(32'hAABBCCDD);
    wq.push_back(32'h01020304);
    run_load(0, 4, 1'b0, 1'b0, 1'b0, "start_ignored");
    // reset during the WRITE that follows byte 6
    wq.delete();
    wq.push_back(32'hDEADBEEF);
    wq.push_back(32'h0000002A);
    build(1'b0);
    send_all(0, 6, 0, -1);
    reset = 1'b1;
    #1;
    chk_reset("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wq.delete();
    wq.push_back(32'h11223344);
    run_load(0, -1, 1'b0, 1'b0, 1'b0, "after_reset");
`ifdef INST_LOADER_CHECKSUM_EN
    run_load(0, -1, 1'b1, 1'b1, 1'b1, "bad_checksum");
    run_load(0, -1, 1'b0, 1'b0, 1'b0, "good_checksum");
`endif
    for (int r = 0; r < 15; r++) begin
      wq.delete();
      repeat ($urandom_range(1, 6)) wq.push_back($urandom);
      run_load(2, -1, 1'b0, 1'b0, 1'b0, $sformatf("rand%0d", r));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
